// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// IMEM_* defaults must track the instruction memory's own depth and base address.
package instr_loader_pkg;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned IMEM_DEPTH     = 1024;
    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader connects through the slave modport; the stream source and memory use master.
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [WORD_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid_o pulses combinationally
// in the cycle the 4th byte of a group is accepted, with word_o holding the full word.
module instr_loader_byte_packer
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;

    always_comb begin
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        word_valid_o = 1'b0;
        word_o       = {sh_q, byte_i};
        if (clear_i) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (accept_i) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                word_valid_o = 1'b1;
                sh_d         = '0;
            end else begin
                sh_d = {sh_q[15:0], byte_i};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory writer: reads a word count N then N big-endian words from a byte stream,
// writes them from BASE_ADDR upward and holds the CPU until the whole image is in place.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = IMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    instr_loader_if.slave    bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [WORD_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  n_q, n_d;

    logic              receiving;
    logic              accept;
    logic              start_go;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  idx_next;

    // in_ready lags state by one cycle, so a byte offered in the cycle after the last
    // write can be handshaken while the FSM is already in DONE; it is dropped.
    assign receiving = (state_q == StLen) || (state_q == StData);
    assign accept    = bus.in_valid && in_ready_q && receiving;
    assign start_go  = start && !receiving;
    assign idx_next  = idx_q + CNT_W'(1);

    instr_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_go),
        .accept_i     (accept),
        .byte_i       (bus.in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d    = state_q;
        in_ready_d = receiving;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        word_cnt_d = word_cnt_q;
        idx_d      = idx_q;
        n_d        = n_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_go) begin
                    state_d    = StLen;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    word_cnt_d = '0;
                    wr_addr_d  = BASE_ADDR;
                    idx_d      = '0;
                end
            end
            StLen: begin
                if (word_valid) begin
                    if (word == '0) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (word > DEPTH) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StData;
                        n_d     = word[CNT_W-1:0];
                        idx_d   = '0;
                    end
                end
            end
            StData: begin
                if (word_valid) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = word;
                    wr_addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                    word_cnt_d = idx_next;
                    idx_d      = idx_next;
                    if (idx_next == n_q) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            idx_q      <= '0;
            n_q        <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: expected writes are queued as images are driven
// and compared by a write monitor; status outputs are checked at the end of each load.
module tb_instr_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [10:0] cnt;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [10:0] word_cnt;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    wr_t exp_q[$];

    instr_loader_if bus ();

    instr_loader #(
        .DEPTH     (1024),
        .BASE_ADDR (32'h0000_0000),
        .CNT_W     (11)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every wr_en pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected_queue_size", exp_q.size(), 1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("wr_addr", bus.wr_addr, e.addr);
                check_eq("wr_data", bus.wr_data, e.data);
                check_eq("wr_word_cnt", word_cnt, e.cnt);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_eq("in_ready_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [10:0] c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || err) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("end_reached", done | err, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_final(input string tag, input logic d, input logic e, input logic h,
                               input logic [10:0] c, input int writes, input int wr_before);
        check_eq({tag, "_done"}, done, d);
        check_eq({tag, "_err"}, err, e);
        check_eq({tag, "_cpu_hold"}, cpu_hold, h);
        check_eq({tag, "_word_cnt"}, word_cnt, c);
        check_eq({tag, "_in_ready"}, bus.in_ready, 0);
        check_eq({tag, "_writes"}, wr_seen - wr_before, writes);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_in_ready"}, bus.in_ready, 0);
        check_eq({tag, "_wr_en"}, bus.wr_en, 0);
        check_eq({tag, "_wr_addr"}, bus.wr_addr, 32'h0);
        check_eq({tag, "_wr_data"}, bus.wr_data, 32'h0);
        check_eq({tag, "_cpu_hold"}, cpu_hold, 1);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Two-word image, no gaps.
        base = wr_seen;
        pulse_start();
        expect_wr(32'h0, 32'h2008_0005, 11'd1);
        expect_wr(32'h4, 32'h2009_0007, 11'd2);
        send_word(32'h0000_0002, 0);
        send_word(32'h2008_0005, 0);
        send_word(32'h2009_0007, 0);
        wait_end();
        check_final("img2", 1, 0, 0, 11'd2, 2, base);

        // Same image with 3-cycle stalls between bytes; restart state checked first.
        base = wr_seen;
        pulse_start();
        check_eq("restart_done", done, 0);
        check_eq("restart_cpu_hold", cpu_hold, 1);
        check_eq("restart_word_cnt", word_cnt, 0);
        check_eq("restart_wr_addr", bus.wr_addr, 32'h0);
        expect_wr(32'h0, 32'h2008_0005, 11'd1);
        expect_wr(32'h4, 32'h2009_0007, 11'd2);
        send_word(32'h0000_0002, 3);
        send_word(32'h2008_0005, 3);
        send_word(32'h2009_0007, 3);
        wait_end();
        check_final("gaps", 1, 0, 0, 11'd2, 2, base);

        // Oversized header, then recovery with a one-word image.
        base = wr_seen;
        pulse_start();
        send_word(32'h0000_0401, 0);
        wait_end();
        check_final("oversize", 0, 1, 1, 11'd0, 0, base);
        base = wr_seen;
        pulse_start();
        check_eq("err_cleared", err, 0);
        expect_wr(32'h0, 32'hDEAD_BEEF, 11'd1);
        send_word(32'h0000_0001, 0);
        send_word(32'hDEAD_BEEF, 0);
        wait_end();
        check_final("recover", 1, 0, 0, 11'd1, 1, base);

        // Zero-length image.
        base = wr_seen;
        pulse_start();
        send_word(32'h0000_0000, 0);
        wait_end();
        check_final("empty", 1, 0, 0, 11'd0, 0, base);

        // Reset after 6 bytes of a 3-word load.
        base = wr_seen;
        pulse_start();
        send_word(32'h0000_0003, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        check_eq("midrst_writes", wr_seen - base, 0);
        pulse_start();
        expect_wr(32'h0, 32'h1122_3344, 11'd1);
        send_word(32'h0000_0001, 0);
        send_word(32'h1122_3344, 0);
        wait_end();
        check_final("after_rst", 1, 0, 0, 11'd1, 1, base);

        // Start during DATA is ignored; then a fresh one-word load restarts indexing.
        base = wr_seen;
        pulse_start();
        expect_wr(32'h0, 32'hA0A0_A0A0, 11'd1);
        expect_wr(32'h4, 32'hB1B2_B3B4, 11'd2);
        send_word(32'h0000_0002, 0);
        send_word(32'hA0A0_A0A0, 0);
        pulse_start();
        send_word(32'hB1B2_B3B4, 0);
        wait_end();
        check_final("start_in_data", 1, 0, 0, 11'd2, 2, base);
        base = wr_seen;
        pulse_start();
        expect_wr(32'h0, 32'hC0FF_EE00, 11'd1);
        send_word(32'h0000_0001, 0);
        send_word(32'hC0FF_EE00, 0);
        wait_end();
        check_final("reload", 1, 0, 0, 11'd1, 1, base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
